// File: rtl/log_pkg.sv
// Shared types and constants for the EEPROM log write scheduler.
// Holds the FSM encoding, record geometry and the last legal record address.
package log_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_BACKOFF = 3'd4
  } log_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  localparam int unsigned REC_W      = 64;
  localparam int unsigned REC_STRIDE = 8;
  localparam logic [14:0] TOP_ADDR   = 15'h7FF8;

  // Record counter holds at all-ones instead of rolling back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/log_write_scheduler_if.sv
// Requester, I2C page-write engine and status signals of the log scheduler.
// The scheduler takes the master modport; the surrounding system takes slave.
interface log_write_scheduler_if #(
  parameter int unsigned ADDR_W = 15
);
  logic                     req_a;
  logic                     req_b;
  logic [log_pkg::REC_W-1:0] data_a;
  logic [log_pkg::REC_W-1:0] data_b;
  logic                     ack_a;
  logic                     ack_b;
  logic                     wr_start;
  logic [ADDR_W-1:0]        wr_addr;
  logic [log_pkg::REC_W-1:0] wr_data;
  logic                     wr_busy;
  logic                     wr_done;
  logic                     wr_nack;
  logic                     WP;
  logic [15:0]              rec_count;
  logic                     wrapped;
  logic                     err;

  modport master (
    input  req_a, req_b, data_a, data_b, wr_busy, wr_done, wr_nack,
    output ack_a, ack_b, wr_start, wr_addr, wr_data, WP, rec_count, wrapped, err
  );

  modport slave (
    output req_a, req_b, data_a, data_b, wr_busy, wr_done, wr_nack,
    input  ack_a, ack_b, wr_start, wr_addr, wr_data, WP, rec_count, wrapped, err
  );
endinterface

// File: rtl/log_rr_arbiter.sv
// Two-requester round-robin arbiter; grants are combinational, and the
// last-granted requester is remembered only when the scheduler accepts.
module log_rr_arbiter
  import log_pkg::*;
(
  input  logic CLK_50MHz,
  input  logic RESET,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  grant_e last_q;
  grant_e last_d;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      gnt_a = (last_q == GNT_B);
      gnt_b = (last_q == GNT_A);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept && gnt_a) begin
      last_d = GNT_A;
    end else if (accept && gnt_b) begin
      last_d = GNT_B;
    end else begin
      last_d = last_q;
    end
  end

  // Reset to B so that the very first contested grant goes to A.
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      last_q <= GNT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/log_write_scheduler.sv
// Schedules 64-bit log records from two requesters into sequential 8-byte
// slots of a 24LC256, with NACK backoff/retry, pointer wrap and status flags.
module log_write_scheduler
  import log_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 15'h0000,
  parameter int unsigned       MAX_RETRY = 4,
  parameter int unsigned       RETRY_GAP = 25000
) (
  input logic                   CLK_50MHz,
  input logic                   RESET,
  log_write_scheduler_if.master bus
);

  localparam int unsigned       GAP_W    = $clog2(RETRY_GAP + 2);
  localparam int unsigned       RTY_W    = $clog2(MAX_RETRY + 2);
  localparam logic [ADDR_W-1:0] TOP_A    = ADDR_W'(TOP_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(REC_STRIDE);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RETRY_GAP - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

  log_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [REC_W-1:0]  wr_data_q, wr_data_d;
  logic              wr_start_q, wr_start_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              wp_q, wp_d;
  logic [15:0]       rec_count_q, rec_count_d;
  logic              wrapped_q, wrapped_d;
  logic              err_q, err_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              accept_s;
  logic              gnt_a_s;
  logic              gnt_b_s;

  assign accept_s = (state_q == ST_IDLE) && (bus.req_a || bus.req_b) && !bus.wr_busy;

  log_rr_arbiter u_arb (
    .CLK_50MHz (CLK_50MHz),
    .RESET     (RESET),
    .req_a     (bus.req_a),
    .req_b     (bus.req_b),
    .accept    (accept_s),
    .gnt_a     (gnt_a_s),
    .gnt_b     (gnt_b_s)
  );

  // Next-state and output decode; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_start_d  = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    wp_d        = wp_q;
    rec_count_d = rec_count_q;
    wrapped_d   = wrapped_q;
    err_d       = err_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_GRANT;
          wp_d      = 1'b0;
          wr_addr_d = ptr_q;
          if (gnt_a_s) begin
            ack_a_d   = 1'b1;
            wr_data_d = bus.data_a;
          end else if (gnt_b_s) begin
            ack_b_d   = 1'b1;
            wr_data_d = bus.data_b;
          end else begin
            wr_data_d = wr_data_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d    = ST_ISSUE;
        wr_start_d = 1'b1;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A NACK wins over a simultaneous DONE.
        if (bus.wr_nack) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + {{(RTY_W-1){1'b0}}, 1'b1};
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_BACKOFF;
          end else begin
            err_d   = 1'b1;
            retry_d = {RTY_W{1'b0}};
            wp_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bus.wr_done) begin
          if (ptr_q == TOP_A) begin
            ptr_d     = BASE_ADDR;
            wrapped_d = 1'b1;
          end else begin
            ptr_d = ptr_q + STRIDE_A;
          end
          rec_count_d = sat_inc16(rec_count_q);
          retry_d     = {RTY_W{1'b0}};
          wp_d        = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_BACKOFF: begin
        if (gap_q == GAP_LAST) begin
          state_d    = ST_ISSUE;
          wr_start_d = 1'b1;
        end else begin
          gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        wp_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any record in flight.
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= BASE_ADDR;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= {REC_W{1'b0}};
      wr_start_q  <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      wp_q        <= 1'b1;
      rec_count_q <= 16'h0000;
      wrapped_q   <= 1'b0;
      err_q       <= 1'b0;
      retry_q     <= {RTY_W{1'b0}};
      gap_q       <= {GAP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_start_q  <= wr_start_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      wp_q        <= wp_d;
      rec_count_q <= rec_count_d;
      wrapped_q   <= wrapped_d;
      err_q       <= err_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.wr_start  = wr_start_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.WP        = wp_q;
  assign bus.rec_count = rec_count_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.err       = err_q;

endmodule
